// File: rtl/btn_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// btn_cmd_scheduler
//
// Serialises single-cycle debounced button pulses into one command stream
// for the game FSM. Each button owns one pending-request bit. Requests are
// granted one at a time in round-robin order and presented on a valid/ready
// handshake. After each accepted command the scheduler waits GAP_CYCLES idle
// cycles before it grants again. A press that arrives while its button is
// already pending is lost and sets a sticky drop flag.
//
// Handshake: Cmd_valid rises when a command is granted and stays high, with
// Cmd_code unchanged, until a rising CLK edge sees Cmd_ready=1. That edge is
// the accept. Cmd_valid is never withdrawn before the accept, even if Enable
// falls.
//
// Ports
//   CLK         in   1      system clock (shared with the debouncers)
//   RESET       in   1      asynchronous, active-high reset
//   Enable      in   1      1 = latch and grant presses, 0 = ignore/flush
//   Btn_pulse   in   N_BTN  one-cycle debounced presses, bit i = button i
//   Cmd_ready   in   1      consumer accepts when high with Cmd_valid high
//   Clear_drop  in   1      synchronous clear of Drop_flag
//   Cmd_valid   out  1      command available on Cmd_code
//   Cmd_code    out  3      index of the granted button
//   Pending     out  N_BTN  latched, not-yet-granted requests
//   Drop_flag   out  1      sticky: press lost because already pending
//   dbg_state   out  2      FSM state (0 idle, 1 hold, 2 gap)
// ---------------------------------------------------------------------------
module btn_cmd_scheduler #(
  parameter int N_BTN      = 5,
  parameter int GAP_CYCLES = 244,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Enable,
  input  logic [N_BTN-1:0] Btn_pulse,
  input  logic             Cmd_ready,
  input  logic             Clear_drop,
  output logic             Cmd_valid,
  output logic [2:0]       Cmd_code,
  output logic [N_BTN-1:0] Pending,
  output logic             Drop_flag,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Last count value of the gap; unused when GAP_CYCLES is 0.
  localparam logic [CNT_W-1:0] GAP_LAST =
    (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
  // Pointer starts at the last button so the first search begins at 0.
  localparam logic [2:0] RR_INIT = 3'(N_BTN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         rr_q, rr_d;
  logic [2:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic [N_BTN-1:0]   pend_q, pend_d;
  logic               drop_q, drop_d;

  logic               pick_found;
  logic [2:0]         pick_idx;
  logic [N_BTN-1:0]   grant;
  logic [N_BTN-1:0]   new_drops;

  // base + off, wrapped modulo N_BTN. base < N_BTN and off <= N_BTN, so a
  // single subtraction is enough.
  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_BTN) s = s - N_BTN;
    return 3'(s);
  endfunction

  // Round-robin search: first pending bit strictly after the last grant.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      if (!pick_found && pend_q[wrap_idx(rr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(rr_q, k);
      end
    end
  end

  // Control FSM: next state and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    code_d  = code_q;
    valid_d = valid_q;
    grant   = '0;
    case (state_q)
      ST_IDLE: begin
        if (Enable && pick_found) begin
          grant[pick_idx] = 1'b1;
          code_d          = pick_idx;
          valid_d         = 1'b1;
          rr_d            = pick_idx;
          state_d         = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (Cmd_ready) begin
          valid_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Pending latch and drop detection. A pulse on the grant edge re-arms the
  // bit (set wins over the grant's clear) and is not a drop, since the
  // earlier request has just been consumed.
  always_comb begin
    pend_d    = '0;
    new_drops = '0;
    if (Enable) begin
      new_drops = Btn_pulse & pend_q & ~grant;
      pend_d    = Btn_pulse | (pend_q & ~grant);
    end
    drop_d = drop_q;
    if (|new_drops) begin
      drop_d = 1'b1;
    end else if (Clear_drop) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rr_q    <= RR_INIT;
      code_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign Cmd_valid = valid_q;
  assign Cmd_code  = code_q;
  assign Pending   = pend_q;
  assign Drop_flag = drop_q;
  assign dbg_state = state_q;

endmodule
